// File: rtl/difftest_commit_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : difftest_commit_queue
// Purpose  : Retire-trace buffer between core commit ports and the co-sim
//            checker. Packs up to COMMITS retirements plus one trap per cycle
//            in program order into a DEPTH-entry FIFO and drains one entry per
//            cycle over valid/ready. Groups that do not fit are dropped whole,
//            counted and latched in a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module difftest_commit_queue #(
  parameter int COMMITS = 2,
  parameter int XLEN    = 64,
  parameter int DEPTH   = 16,
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [COMMITS-1:0]      in_valid,
  input  logic [COMMITS*XLEN-1:0] in_pc,
  input  logic [COMMITS*32-1:0]   in_insn,
  input  logic [COMMITS-1:0]      in_wen,
  input  logic [COMMITS*5-1:0]    in_waddr,
  input  logic [COMMITS*XLEN-1:0] in_wdata,
  input  logic                    trap_valid,
  input  logic [XLEN-1:0]         trap_cause,
  input  logic                    flush,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_kind,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_insn,
  output logic                    out_wen,
  output logic [4:0]              out_waddr,
  output logic [XLEN-1:0]         out_wdata,
  output logic [CW-1:0]           count,
  output logic                    overflow,
  output logic [63:0]             commit_cnt,
  output logic [31:0]             drop_cnt
);

  localparam int            c_pw    = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_need  = CW'(COMMITS + 1);

  // Entry storage; payload is only ever observed while the entry is live.
  logic            r_mem_kind  [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [31:0]     r_mem_insn  [DEPTH];
  logic            r_mem_wen   [DEPTH];
  logic [4:0]      r_mem_waddr [DEPTH];
  logic [XLEN-1:0] r_mem_wdata [DEPTH];

  logic [c_pw-1:0] r_head;
  logic [c_pw-1:0] r_tail;
  logic [CW-1:0]   r_count;
  logic            r_in_ready;
  logic            r_overflow;
  logic [63:0]     r_commit_cnt;
  logic [31:0]     r_drop_cnt;

  logic [CW-1:0]   w_acc;
  logic [c_pw-1:0] w_widx [COMMITS+1];
  logic [CW-1:0]   w_ncommit;
  logic [CW-1:0]   w_n;
  logic [CW-1:0]   w_free;
  logic            w_fits;
  logic            w_accept;
  logic            w_drop;
  logic            w_deq;
  logic [CW-1:0]   w_count_next;
  logic [32:0]     w_drop_sum;

  // Packing: each valid slot lands at tail + (number of valid older slots);
  // the trap entry goes right after the last commit of the group.
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < COMMITS; i++) begin
      w_widx[i] = r_tail + w_acc[c_pw-1:0];
      w_acc     = w_acc + CW'(in_valid[i]);
    end
    w_widx[COMMITS] = r_tail + w_acc[c_pw-1:0];
    w_ncommit       = w_acc;
  end

  // Group acceptance uses the start-of-cycle occupancy, so a same-cycle
  // dequeue never makes room for the incoming group.
  always_comb begin
    w_n          = w_ncommit + CW'(trap_valid);
    w_free       = c_depth - r_count;
    w_fits       = (w_free >= w_n);
    w_accept     = !flush && w_fits;
    w_drop       = !flush && (w_n != '0) && !w_fits;
    w_deq        = !flush && (r_count != '0) && out_ready;
    w_count_next = flush ? '0
                 : (r_count + (w_accept ? w_n : '0) - CW'(w_deq));
    w_drop_sum   = {1'b0, r_drop_cnt} + 33'(w_n);
  end

  // Entry writes for an accepted group (no reset: liveness is tracked by count).
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int i = 0; i < COMMITS; i++) begin
        if (in_valid[i]) begin
          r_mem_kind[w_widx[i]]  <= 1'b0;
          r_mem_pc[w_widx[i]]    <= in_pc[i*XLEN +: XLEN];
          r_mem_insn[w_widx[i]]  <= in_insn[i*32 +: 32];
          r_mem_wen[w_widx[i]]   <= in_wen[i];
          r_mem_waddr[w_widx[i]] <= in_waddr[i*5 +: 5];
          r_mem_wdata[w_widx[i]] <= in_wdata[i*XLEN +: XLEN];
        end
      end
      if (trap_valid) begin
        r_mem_kind[w_widx[COMMITS]]  <= 1'b1;
        r_mem_pc[w_widx[COMMITS]]    <= '0;
        r_mem_insn[w_widx[COMMITS]]  <= '0;
        r_mem_wen[w_widx[COMMITS]]   <= 1'b0;
        r_mem_waddr[w_widx[COMMITS]] <= '0;
        r_mem_wdata[w_widx[COMMITS]] <= trap_cause;
      end
    end
  end

  // Pointers, occupancy, status flags and statistics counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_in_ready   <= 1'b0;
      r_overflow   <= 1'b0;
      r_commit_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= ((c_depth - w_count_next) >= c_need);
      if (flush) begin
        r_head     <= '0;
        r_tail     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_deq) begin
          r_head <= r_head + c_pw'(1);
        end
        if (w_accept) begin
          r_tail <= r_tail + w_n[c_pw-1:0];
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end
      if (w_accept) begin
        r_commit_cnt <= r_commit_cnt + 64'(w_ncommit);
      end
      if (w_drop) begin
        r_drop_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_kind   = out_valid ? r_mem_kind[r_head]  : 1'b0;
  assign out_pc     = out_valid ? r_mem_pc[r_head]    : '0;
  assign out_insn   = out_valid ? r_mem_insn[r_head]  : '0;
  assign out_wen    = out_valid ? r_mem_wen[r_head]   : 1'b0;
  assign out_waddr  = out_valid ? r_mem_waddr[r_head] : '0;
  assign out_wdata  = out_valid ? r_mem_wdata[r_head] : '0;
  assign in_ready   = r_in_ready;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign commit_cnt = r_commit_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_difftest_commit_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_difftest_commit_queue
// Purpose  : Self-checking bench for difftest_commit_queue (COMMITS=2,
//            DEPTH=16). Vector table plus hand-written corner sequences, with
//            a scoreboard queue holding the expected drain order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_difftest_commit_queue;
  localparam int COMMITS = 2;
  localparam int XLEN    = 64;
  localparam int DEPTH   = 16;
  localparam int CW      = 5;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [COMMITS-1:0]      in_valid;
  logic [COMMITS*XLEN-1:0] in_pc;
  logic [COMMITS*32-1:0]   in_insn;
  logic [COMMITS-1:0]      in_wen;
  logic [COMMITS*5-1:0]    in_waddr;
  logic [COMMITS*XLEN-1:0] in_wdata;
  logic                    trap_valid;
  logic [XLEN-1:0]         trap_cause;
  logic                    flush;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_kind;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_insn;
  logic                    out_wen;
  logic [4:0]              out_waddr;
  logic [XLEN-1:0]         out_wdata;
  logic [CW-1:0]           count;
  logic                    overflow;
  logic [63:0]             commit_cnt;
  logic [31:0]             drop_cnt;

  difftest_commit_queue #(
    .COMMITS(COMMITS), .XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .flush(flush),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc), .out_insn(out_insn),
    .out_wen(out_wen), .out_waddr(out_waddr), .out_wdata(out_wdata),
    .count(count), .overflow(overflow),
    .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        kind;
    logic [63:0] pc;
    logic [31:0] insn;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
  } entry_t;

  typedef struct {
    logic [1:0] v;
    logic       t;
    logic       r;
    logic       f;
    int         cnt;
    logic       vld;
    logic       ovf;
    logic       rdy;
    int         drop;
    longint     commit;
  } vec_t;

  entry_t      sb[$];
  vec_t        tbl[$];
  int          checks   = 0;
  int          failures = 0;
  longint      m_commit = 0;
  longint      m_drop   = 0;
  bit          m_ovf    = 0;
  logic [63:0] pc_ctr   = 64'h1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] v, input logic t, input logic r, input logic f,
                     input int cnt, input logic vld, input logic ovf, input logic rdy,
                     input int drop, input longint commit);
    vec_t x;
    x.v = v; x.t = t; x.r = r; x.f = f; x.cnt = cnt; x.vld = vld;
    x.ovf = ovf; x.rdy = rdy; x.drop = drop; x.commit = commit;
    tbl.push_back(x);
  endtask

  // Sequential pcs for valid slots, junk in holes; other fields derived from pc.
  task automatic set_payload(input logic [1:0] v);
    logic [63:0] pc;
    for (int i = 0; i < COMMITS; i++) begin
      if (v[i]) begin
        pc = pc_ctr;
        pc_ctr = pc_ctr + 64'd4;
      end else begin
        pc = {$urandom, $urandom};
      end
      in_pc[i*XLEN +: XLEN]    = pc;
      in_insn[i*32 +: 32]      = {pc[15:0], 16'h0013};
      in_wen[i]                = pc[2];
      in_waddr[i*5 +: 5]       = pc[6:2];
      in_wdata[i*XLEN +: XLEN] = ~pc;
    end
    trap_cause = 64'h8;
  endtask

  // One cycle: drive at negedge, check head against the scoreboard, update
  // the model, then check the post-edge state.
  task automatic apply(input logic [1:0] v, input logic t, input logic r, input logic f);
    int     pre;
    int     n;
    entry_t e;
    @(negedge clock);
    in_valid = v; trap_valid = t; out_ready = r; flush = f;
    #1;
    pre = sb.size();
    if (pre != 0) begin
      check("head_valid", out_valid, 1);
      check("head_kind",  out_kind,  sb[0].kind);
      check("head_pc",    out_pc,    sb[0].pc);
      check("head_insn",  out_insn,  sb[0].insn);
      check("head_wen",   out_wen,   sb[0].wen);
      check("head_waddr", out_waddr, sb[0].waddr);
      check("head_wdata", out_wdata, sb[0].wdata);
      if (r && !f) void'(sb.pop_front());
    end
    n = $countones(v) + int'(t);
    if (f) begin
      sb.delete();
      m_ovf = 0;
    end else if (n > 0) begin
      if (DEPTH - pre >= n) begin
        for (int i = 0; i < COMMITS; i++) begin
          if (v[i]) begin
            e.kind  = 1'b0;
            e.pc    = in_pc[i*XLEN +: XLEN];
            e.insn  = in_insn[i*32 +: 32];
            e.wen   = in_wen[i];
            e.waddr = in_waddr[i*5 +: 5];
            e.wdata = in_wdata[i*XLEN +: XLEN];
            sb.push_back(e);
            m_commit++;
          end
        end
        if (t) begin
          e.kind = 1'b1; e.pc = '0; e.insn = '0; e.wen = 1'b0; e.waddr = '0;
          e.wdata = trap_cause;
          sb.push_back(e);
        end
      end else begin
        m_ovf  = 1;
        m_drop = m_drop + n;
        if (m_drop > 64'hffff_ffff) m_drop = 64'hffff_ffff;
      end
    end
    @(posedge clock);
    #1;
    check("count",      count,      sb.size());
    check("out_valid",  out_valid,  sb.size() != 0);
    check("overflow",   overflow,   m_ovf);
    check("in_ready",   in_ready,   (DEPTH - sb.size()) >= COMMITS + 1);
    check("commit_cnt", commit_cnt, m_commit);
    check("drop_cnt",   drop_cnt,   m_drop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; in_valid = '0; in_pc = '0; in_insn = '0; in_wen = '0;
    in_waddr = '0; in_wdata = '0; trap_valid = 1'b0; trap_cause = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Ordering, backpressure/overflow, full with dequeue, drain, flush.
    add(2'b11, 0, 1, 0, 2, 1, 0, 1, 0, 2);
    add(2'b10, 1, 1, 0, 3, 1, 0, 1, 0, 3);
    add(2'b00, 0, 1, 0, 2, 1, 0, 1, 0, 3);
    add(2'b00, 0, 1, 0, 1, 1, 0, 1, 0, 3);
    add(2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 3);
    add(2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 3);
    for (int k = 1; k <= 7; k++)
      add(2'b11, 0, 0, 0, 2*k, 1, 0, (k < 7), 0, 3 + 2*k);
    add(2'b11, 0, 0, 0, 16, 1, 0, 0, 0, 19);
    add(2'b11, 0, 0, 0, 16, 1, 1, 0, 2, 19);
    add(2'b01, 0, 1, 0, 15, 1, 1, 0, 3, 19);
    for (int k = 1; k <= 15; k++)
      add(2'b00, 0, 1, 0, 15 - k, (15 - k) != 0, 1, (16 - (15 - k)) >= 3, 3, 19);
    add(2'b11, 0, 0, 0, 2, 1, 1, 1, 3, 21);
    add(2'b11, 0, 0, 0, 4, 1, 1, 1, 3, 23);
    add(2'b01, 0, 0, 0, 5, 1, 1, 1, 3, 24);
    add(2'b11, 0, 1, 1, 0, 0, 0, 1, 3, 24);

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid",  out_valid,  0);
    check("rst_count",      count,      0);
    check("rst_overflow",   overflow,   0);
    check("rst_in_ready",   in_ready,   0);
    check("rst_commit_cnt", commit_cnt, 0);
    check("rst_drop_cnt",   drop_cnt,   0);
    check("rst_out_pc",     out_pc,     0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      set_payload(tbl[i].v);
      apply(tbl[i].v, tbl[i].t, tbl[i].r, tbl[i].f);
      check("tbl_count",     count,      tbl[i].cnt);
      check("tbl_valid",     out_valid,  tbl[i].vld);
      check("tbl_overflow",  overflow,   tbl[i].ovf);
      check("tbl_in_ready",  in_ready,   tbl[i].rdy);
      check("tbl_drop_cnt",  drop_cnt,   tbl[i].drop);
      check("tbl_commit",    commit_cnt, tbl[i].commit);
    end

    // Hole packing: only slot 1 valid
    in_pc    = {64'h2000, 64'h0bad};
    in_insn  = {32'h00a00293, 32'hffff_ffff};
    in_wen   = 2'b10;
    in_waddr = {5'd5, 5'd31};
    in_wdata = {64'hdead, 64'h1234};
    apply(2'b10, 0, 0, 0);
    check("hole_count", count,     1);
    check("hole_kind",  out_kind,  0);
    check("hole_pc",    out_pc,    64'h2000);
    check("hole_wen",   out_wen,   1);
    check("hole_waddr", out_waddr, 5);
    check("hole_wdata", out_wdata, 64'hdead);
    apply(2'b00, 0, 1, 0);

    // Asynchronous reset mid-drain with overflow set
    for (int k = 0; k < 9; k++) begin
      set_payload(2'b11);
      apply(2'b11, 0, 0, 0);
    end
    apply(2'b00, 0, 1, 0);
    check("pre_rst_count", count, 15);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid",  out_valid,  0);
    check("arst_count",      count,      0);
    check("arst_overflow",   overflow,   0);
    check("arst_in_ready",   in_ready,   0);
    check("arst_commit_cnt", commit_cnt, 0);
    check("arst_drop_cnt",   drop_cnt,   0);
    sb.delete();
    m_commit = 0; m_drop = 0; m_ovf = 0;
    @(negedge clock);
    reset_n = 1'b1;
    pc_ctr = 64'h3000;
    set_payload(2'b01);
    apply(2'b01, 0, 0, 0);
    check("post_rst_pc", out_pc, 64'h3000);
    apply(2'b00, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/difftest_commit_queue.md
# difftest_commit_queue

Parametrised retire-trace buffer between the DUT core's commit ports and the co-simulation checker. Each cycle it captures up to COMMITS retired instructions plus an optional trap event, packs them in program order into a DEPTH-entry FIFO, and drains one entry per cycle over a valid/ready port, so a checker that stalls does not lose commits. Overflow is detected, counted and latched; it is never silent.

## Interface
- COMMITS, 2, retire slots per cycle (1..4); slot 0 is oldest
- XLEN, 64, PC/data/cause width
- DEPTH, 16, FIFO entries; power of two, ≥ COMMITS+1
- CW, $clog2(DEPTH)+1, occupancy width (derived)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  COMMITS  per-slot retire valid; any pattern allowed, including holes
- in_pc  in  COMMITS*XLEN  slot i at [i*XLEN +: XLEN]
- in_insn  in  COMMITS*32  instruction word per slot
- in_wen  in  COMMITS  integer register write per slot
- in_waddr  in  COMMITS*5  destination register per slot
- in_wdata  in  COMMITS*XLEN  write data per slot
- trap_valid  in  1  trap raised this cycle; ordered after all of this cycle's commits
- trap_cause  in  XLEN  trap cause
- flush  in  1  synchronous queue clear
- in_ready  out  1  registered; 1 when free entries ≥ COMMITS+1
- out_valid  out  1  head entry valid
- out_ready  in  1  checker accepts head
- out_kind  out  1  0 = commit, 1 = trap
- out_pc, out_insn, out_wen, out_waddr  out  XLEN/32/1/5  head commit fields; 0 for traps
- out_wdata  out  XLEN  commit write data, or trap cause when out_kind=1
- count  out  CW  occupancy
- overflow  out  1  sticky drop flag
- commit_cnt  out  64  accepted commit entries (wraps)
- drop_cnt  out  32  dropped entries (saturates at 2^32-1)

## Operation
- Cycle group: n = popcount(in_valid) + trap_valid, range 0..COMMITS+1.
- Packing: valid slots are written in ascending slot order to consecutive tail positions, skipping holes. The trap entry is written last.
- Atomic acceptance: the group is accepted iff DEPTH − count ≥ n. count is the registered value at the start of the cycle; it ignores a same-cycle dequeue.
- Rejected group (n>0, insufficient space): no entry is written. overflow ← 1. drop_cnt += n (saturating). in_ready is advisory only: the core never stalls, so drops are possible.
- Dequeue: when out_valid && out_ready, head advances by one.
- count_next = count + (accepted ? n : 0) − deq. Simultaneous enqueue and dequeue are legal, including at full and at empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count disambiguates full from empty.
- commit_cnt += number of accepted commit entries (trap entries excluded).
- flush: empties the queue and clears overflow. Same-cycle input is discarded and does not count as a drop. commit_cnt and drop_cnt are kept. A same-cycle dequeue is ignored.
- Reset: all outputs 0, pointers 0, overflow 0. Asserting reset_n=0 mid-operation discards all entries immediately.

## Timing
- Enqueue-to-out_valid latency is 1 cycle. An entry written at edge k is visible after edge k.
- Output payload is driven from storage at the head pointer. It is held stable while out_valid && !out_ready.
- out_valid = (count ≠ 0); there is no combinational path from in_* to out_*.
- in_ready and overflow are registered, updated each edge from count_next.
- Throughput is 1 dequeue per cycle. Sustained input above 1 entry/cycle eventually drops.
- Drain order strictly equals packing order across cycles.

## Test plan
- Ordering: COMMITS=2; cycle 0: in_valid=2'b11, pc 0x1000/0x1004; cycle 1: in_valid=2'b10, pc 0x1008, trap_valid=1, cause 0x8; out_ready=1 → out sequence: 0x1000, 0x1004, 0x1008 (kind 0), then kind 1 with out_wdata 0x8. out_valid first high 1 cycle after cycle 0. commit_cnt ends at 3.
- Hole packing: in_valid=2'b10, slot 1 pc 0x2000 wen=1 waddr=5 wdata=0xdead → exactly one entry: pc 0x2000, waddr 5, wdata 0xdead. count=1.
- Backpressure: DEPTH=16, out_ready=0, 2 commits/cycle for 7 cycles → count=14, in_ready falls when free <3. 8th group (n=2) accepted → count=16. 9th group → dropped: overflow=1, drop_cnt=2, count stays 16. Raise out_ready → 16 entries drain in order, payload stable while stalled.
- Full with simultaneous dequeue: count=16, out_ready=1, group n=1 → rejected (pre-dequeue count rule), count=15, drop_cnt=1.
- Flush: count=5, overflow=1, flush=1 with in_valid=2'b11 → next cycle count=0, out_valid=0, overflow=0, commit_cnt and drop_cnt unchanged.
- Async reset: reset_n low mid-drain, no clock edge → out_valid, count, overflow and counters read 0 immediately. After release, the first group enqueues at pointer 0.
